mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Two-master arbiter that shares the single Data_Memory port between the
//   instruction-side cache (m0) and dcache_top (m1). It sits between the
//   caches' mem_* interfaces and Data_Memory. It sequences each transfer
//   (grant, hold until ack, one-cycle release) and selects masters by
//   round-robin or fixed priority.
// PARAMETERS
//   ADDR_W  32   address width of all ports
//   DATA_W  256  line width of all data ports
//   RR_EN   1    1 = round-robin on ties; 0 = fixed priority, m1 always wins ties
// PORTS
//   clk_i          in   1       clock, rising edge
//   rst_i          in   1       asynchronous reset, active-low
//   m0_enable_i    in   1       m0 request; held high until m0_ack_o
//   m0_write_i     in   1       m0 1=write 0=read; stable while requesting
//   m0_addr_i      in   ADDR_W  m0 line address
//   m0_data_i      in   DATA_W  m0 write data
//   m0_data_o      out  DATA_W  m0 read data; valid only with m0_ack_o
//   m0_ack_o       out  1       m0 one-cycle completion pulse
//   m1_*           same six signals as m0_*, for master 1 (dcache)
//   mem_enable_o   out  1       to Data_Memory enable_i
//   mem_write_o    out  1       to Data_Memory write_i
//   mem_addr_o     out  ADDR_W  to Data_Memory addr_i
//   mem_data_o     out  DATA_W  to Data_Memory data_i
//   mem_data_i     in   DATA_W  from Data_Memory data_o
//   mem_ack_i      in   1       from Data_Memory ack_o, one-cycle pulse
//   grant_o        out  2       one-hot current owner: [0]=m0, [1]=m1
//   err_o          out  1       sticky protocol error flag
// BEHAVIOUR
// - Reset (rst_i=0, async): state=IDLE, last=m1, err_o=0.
//   All outputs are 0, including mem_* and m*_ack_o.
// - States:
//   IDLE: mem_enable_o=0. Sample requests, pick a winner, go to GNT0 or GNT1.
//     No request -> stay in IDLE.
//   GNTx: mem_enable_o=1 (driven from the state, not from mx_enable_i).
//     mem_write/addr/data come combinationally from master x. grant_o[x]=1.
//     On mem_ack_i: mx_ack_o=1 in the same cycle, last<=x, go to REL.
//   REL: mem_enable_o=0 for exactly one cycle, grant_o=0. Arbitrate as in
//     IDLE: go to GNTx, or to IDLE if no request.
// - Latency:
//   - Request sampled at edge N -> mem_enable_o high after edge N.
//   - mem_ack_i -> mx_ack_o combinationally, same cycle.
// - Arbitration:
//   - Only one master requesting -> grant it.
//   - Both requesting, RR_EN=1 -> grant the master that is not `last`.
//     First tie after reset goes to m0.
//   - Both requesting, RR_EN=0 -> grant m1.
// - m0_data_o and m1_data_o equal mem_data_i at all times. Masters qualify
//   them with their own ack. The non-granted master's ack stays 0.
// - A master sees its enable_i high in the cycle after its ack (the REL
//   cycle) as a new request.
// - Master drops enable_i while granted (violation): the transfer continues
//   until mem_ack_i, then the ack is still delivered. err_o is set.
// - mem_ack_i in IDLE or REL: ignored, no master ack, err_o<=1.
//   err_o clears only on reset.
// - Reset mid-GNTx: the in-flight transfer is abandoned and outputs go to 0
//   immediately. The system resets Data_Memory together with this block.
// TESTING
// 1. m0 read only, addr 0x100, memory ack 10 cycles after enable ->
//    mem_addr_o=0x100 and mem_write_o=0 for 10 cycles. m0_ack_o=1 in the
//    ack cycle with m0_data_o=mem_data_i. mem_enable_o=0 on the next cycle.
// 2. RR_EN=1, m0 and m1 raised together after reset ->
//    m0 served first, then 1 REL cycle, then m1. grant_o=01, 00, 10.
// 3. Both held continuously for 6 transfers: RR_EN=1 -> order 0,1,0,1,0,1.
//    RR_EN=0 -> order 1,1,1,1,1,1 with m0_ack_o never asserted.
// 4. m1 write, addr 0x2C0, data {8{32'hDEADBEEF}} ->
//    mem_write_o=1 and mem_data_o equal to that pattern. m1_ack_o pulses
//    once, m0_ack_o stays 0.
// 5. rst_i=0 mid-GNT1 with m0 pending -> all outputs 0 in the same cycle.
//    After release, m0 is granted first (last=m1).
// 6. mem_ack_i pulse in IDLE -> err_o=1 from the next edge, held through
//    later normal transfers, cleared only by rst_i=0. No m*_ack_o pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single Data_Memory port between two cache masters.
//   m0 = instruction-side cache, m1 = dcache_top.
//   Each transfer: grant (GNTx) and hold until mem_ack_i, then one REL cycle
//   with the memory enable low before the next grant.
// Ports:
//   clk_i, rst_i (async, active-low)
//   m{0,1}_enable_i/write_i/addr_i/data_i : master requests
//   m{0,1}_data_o/ack_o                   : read data (qualified by ack), done pulse
//   mem_enable_o/write_o/addr_o/data_o    : to Data_Memory
//   mem_data_i/ack_i                      : from Data_Memory
//   grant_o : one-hot owner ([0]=m0, [1]=m1), err_o : sticky protocol error
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int RR_EN  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic              err_o
);

  localparam bit RR = (RR_EN != 0);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, REL} state_t;

  state_t state;
  logic   last;   // 1 = m1 was served last, 0 = m0
  logic   err;
  logic   pick1;  // arbitration result: 1 = m1 wins
  logic   g0, g1;

  // Tie: round-robin grants the master not served last; fixed priority favours m1.
  always_comb begin
    pick1 = m1_enable_i;
    if (m0_enable_i && m1_enable_i)
      pick1 = RR ? ~last : 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE, REL: begin
          // an ack with no transfer in flight is a memory-side protocol error
          if (mem_ack_i) err <= 1'b1;
          if (m0_enable_i || m1_enable_i)
            state <= pick1 ? GNT1 : GNT0;
          else
            state <= IDLE;
        end
        GNT0: begin
          // transfer keeps going even if the master drops its request
          if (!m0_enable_i) err <= 1'b1;
          if (mem_ack_i) begin
            state <= REL;
            last  <= 1'b0;
          end
        end
        GNT1: begin
          if (!m1_enable_i) err <= 1'b1;
          if (mem_ack_i) begin
            state <= REL;
            last  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign g0 = (state == GNT0);
  assign g1 = (state == GNT1);

  assign grant_o      = {g1, g0};
  assign mem_enable_o = g0 | g1;
  assign mem_write_o  = (g0 & m0_write_i) | (g1 & m1_write_i);
  assign mem_addr_o   = g0 ? m0_addr_i : (g1 ? m1_addr_i : '0);
  assign mem_data_o   = g0 ? m0_data_i : (g1 ? m1_data_i : '0);

  // read data fans out unqualified; each master qualifies it with its ack
  assign m0_data_o = mem_data_i;
  assign m1_data_o = mem_data_i;
  assign m0_ack_o  = g0 & mem_ack_i;
  assign m1_ack_o  = g1 & mem_ack_i;
  assign err_o     = err;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance a: round-robin
  logic a0_en, a0_wr, a1_en, a1_wr, a0_ack, a1_ack;
  logic [AW-1:0] a0_addr, a1_addr, am_addr;
  logic [DW-1:0] a0_wd, a1_wd, a0_rd, a1_rd, am_wd, am_rd;
  logic am_en, am_wr, am_ack, a_err;
  logic [1:0] a_gnt;

  // instance b: fixed priority
  logic b0_en, b0_wr, b1_en, b1_wr, b0_ack, b1_ack;
  logic [AW-1:0] b0_addr, b1_addr, bm_addr;
  logic [DW-1:0] b0_wd, b1_wd, b0_rd, b1_rd, bm_wd, bm_rd;
  logic bm_en, bm_wr, bm_ack, b_err;
  logic [1:0] b_gnt;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1)) dut_a (
    .clk_i(clk), .rst_i(rst_n),
    .m0_enable_i(a0_en), .m0_write_i(a0_wr), .m0_addr_i(a0_addr), .m0_data_i(a0_wd),
    .m0_data_o(a0_rd), .m0_ack_o(a0_ack),
    .m1_enable_i(a1_en), .m1_write_i(a1_wr), .m1_addr_i(a1_addr), .m1_data_i(a1_wd),
    .m1_data_o(a1_rd), .m1_ack_o(a1_ack),
    .mem_enable_o(am_en), .mem_write_o(am_wr), .mem_addr_o(am_addr), .mem_data_o(am_wd),
    .mem_data_i(am_rd), .mem_ack_i(am_ack), .grant_o(a_gnt), .err_o(a_err));

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(0)) dut_b (
    .clk_i(clk), .rst_i(rst_n),
    .m0_enable_i(b0_en), .m0_write_i(b0_wr), .m0_addr_i(b0_addr), .m0_data_i(b0_wd),
    .m0_data_o(b0_rd), .m0_ack_o(b0_ack),
    .m1_enable_i(b1_en), .m1_write_i(b1_wr), .m1_addr_i(b1_addr), .m1_data_i(b1_wd),
    .m1_data_o(b1_rd), .m1_ack_o(b1_ack),
    .mem_enable_o(bm_en), .mem_write_o(bm_wr), .mem_addr_o(bm_addr), .mem_data_o(bm_wd),
    .mem_data_i(bm_rd), .mem_ack_i(bm_ack), .grant_o(b_gnt), .err_o(b_err));

  int checks = 0;
  int fails  = 0;

  localparam logic [AW-1:0] ADDR0 = 32'h100;
  localparam logic [AW-1:0] ADDR1 = 32'h2C0;
  localparam logic [DW-1:0] BEEF  = {8{32'hDEADBEEF}};
  localparam logic [DW-1:0] DATA0 = {8{32'h0BAD_F00D}};

  typedef struct {
    logic e0, e1, ack;
    logic [1:0] gnt;
    logic k0, k1, err;
  } vec_t;

  function automatic vec_t mk(int e0, int e1, int ack, int gnt, int k0, int k1, int err);
    vec_t v;
    v.e0 = 1'(e0); v.e1 = 1'(e1); v.ack = 1'(ack); v.gnt = 2'(gnt);
    v.k0 = 1'(k0); v.k1 = 1'(k1); v.err = 1'(err);
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] l;
    for (int i = 0; i < DW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // expected winner from the arbitration rules; -1 = nobody requesting
  function automatic int pick(bit e0, bit e1, int last, bit rr);
    if (e0 && e1) return rr ? 1 - last : 1;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [1:0] g, input logic wr,
                       input logic [AW-1:0] ad, input logic [DW-1:0] d,
                       input logic k0, input logic k1, input logic e);
    chk({tag, ".grant"}, DW'(a_gnt), DW'(g));
    chk({tag, ".mem_en"}, DW'(am_en), DW'(|g));
    chk({tag, ".mem_wr"}, DW'(am_wr), DW'(wr));
    chk({tag, ".mem_addr"}, DW'(am_addr), DW'(ad));
    chk({tag, ".mem_data"}, am_wd, d);
    chk({tag, ".ack0"}, DW'(a0_ack), DW'(k0));
    chk({tag, ".ack1"}, DW'(a1_ack), DW'(k1));
    chk({tag, ".err"}, DW'(a_err), DW'(e));
    chk({tag, ".rd0"}, a0_rd, am_rd);
    chk({tag, ".rd1"}, a1_rd, am_rd);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // memory model: ack after a random (or fixed) latency once enabled
  task automatic mem_resp(input logic en, inout int cnt, inout int lat, input int maxlat,
                          output logic ack);
    ack = 1'b0;
    if (en) begin
      if (cnt == 0) lat = $urandom_range(1, maxlat);
      cnt++;
      if (cnt == lat) begin ack = 1'b1; cnt = 0; end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {a0_en, a0_wr, a1_en, a1_wr, am_ack} = '0;
    {b0_en, b0_wr, b1_en, b1_wr, bm_ack} = '0;
    a0_addr = ADDR0; a1_addr = ADDR1; a0_wd = DATA0; a1_wd = BEEF;
    b0_addr = '0; b1_addr = '0; b0_wd = '0; b1_wd = '0;
    am_rd = '0; bm_rd = '0;
    step(); step();
    chk_a("reset", 2'b00, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("reset.b_grant", DW'(b_gnt), '0);
    rst_n = 1'b1;
  endtask

  vec_t tbl[14];
  int order_a[$];
  int nb1, nb0, ca, la, cb, lb;
  int own, last, cyc;
  bit merr, p_e0, p_e1, p_ack;
  logic [1:0] eg;

  initial begin
    // directed sequence: tie after reset, m1 write, spurious ack in IDLE
    //            e0 e1 ak gnt k0 k1 err
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 1, 0, 0, 0);
    tbl[2]  = mk(1, 1, 1, 1, 1, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 2, 0, 0, 0);
    tbl[5]  = mk(0, 1, 1, 2, 0, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 1, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk(1, 0, 0, 1, 0, 0, 1);
    tbl[11] = mk(1, 0, 1, 1, 1, 0, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 1);

    do_reset();
    a1_wr = 1'b1;
    for (int i = 0; i < 14; i++) begin
      a0_en = tbl[i].e0; a1_en = tbl[i].e1; am_ack = tbl[i].ack;
      am_rd = rand_line();
      #1;
      chk_a($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].gnt[1],
            tbl[i].gnt[0] ? ADDR0 : (tbl[i].gnt[1] ? ADDR1 : '0),
            tbl[i].gnt[0] ? DATA0 : (tbl[i].gnt[1] ? BEEF : '0),
            tbl[i].k0, tbl[i].k1, tbl[i].err);
      step();
    end

    // m0 read with a 10-cycle memory latency
    do_reset();
    a0_en = 1'b1;
    #1; chk("t1.idle_en", DW'(am_en), '0);
    step();
    for (int i = 0; i < 10; i++) begin
      am_ack = (i == 9);
      am_rd = rand_line();
      #1;
      chk_a($sformatf("t1.c%0d", i), 2'b01, 1'b0, ADDR0, DATA0, (i == 9), 1'b0, 1'b0);
      step();
    end
    a0_en = 1'b0; am_ack = 1'b0;
    #1; chk("t1.rel_en", DW'(am_en), '0);
    step();

    // master drops request while granted: ack still delivered, err set
    do_reset();
    a1_en = 1'b1; step();
    a1_en = 1'b0;
    #1; chk("viol.grant", DW'(a_gnt), DW'(2'b10));
    step();
    am_ack = 1'b1;
    #1; chk("viol.ack1", DW'(a1_ack), 1); chk("viol.err", DW'(a_err), 1);
    step();
    am_ack = 1'b0;
    #1; chk("viol.rel", DW'(a_gnt), '0);

    // async reset in the middle of a GNT1 transfer, m0 pending
    do_reset();
    a1_en = 1'b1; a1_wr = 1'b1; step();
    a0_en = 1'b1;
    #1; chk("t5.gnt1", DW'(a_gnt), DW'(2'b10));
    #2; rst_n = 1'b0;
    #1;
    chk_a("t5.rst", 2'b00, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    #1; chk("t5.idle", DW'(a_gnt), '0);
    step();
    #1; chk("t5.m0_first", DW'(a_gnt), DW'(2'b01));

    // both masters held for 6 transfers on each instance
    do_reset();
    a0_en = 1'b1; a1_en = 1'b1; b0_en = 1'b1; b1_en = 1'b1;
    nb0 = 0; nb1 = 0; ca = 0; cb = 0; la = 0; lb = 0;
    order_a.delete();
    cyc = 0;
    while ((order_a.size() < 6 || nb1 < 6) && cyc < 300) begin
      mem_resp(am_en, ca, la, 3, am_ack);
      mem_resp(bm_en, cb, lb, 3, bm_ack);
      #1;
      if (a0_ack) order_a.push_back(0);
      if (a1_ack) order_a.push_back(1);
      if (b0_ack) nb0++;
      if (b1_ack) nb1++;
      step();
      cyc++;
    end
    am_ack = 1'b0; bm_ack = 1'b0;
    chk("t3.timeout", DW'(cyc < 300), 1);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t3.rr_order%0d", i), DW'(i < order_a.size() ? order_a[i] : 9), DW'(i % 2));
    chk("t3.fixed_m1", DW'(nb1 >= 6), 1);
    chk("t3.fixed_m0_never", DW'(nb0), 0);

    // randomized traffic against a transfer-level model
    do_reset();
    a1_wr = 1'b0; a1_en = 1'b0; a0_en = 1'b0;
    own = -1; last = 1; merr = 0; p_e0 = 0; p_e1 = 0; p_ack = 0;
    ca = 0; la = 0;
    for (int c = 0; c < 3000; c++) begin
      // a master drops after its ack and may immediately re-request
      if (a0_ack) a0_en = ($urandom_range(0, 1) == 1);
      else if (!a0_en) a0_en = ($urandom_range(0, 9) < 4);
      if (a0_en && (a0_ack || !p_e0)) begin
        a0_wr = 1'($urandom_range(0, 1)); a0_addr = $urandom; a0_wd = rand_line();
      end
      if (a1_ack) a1_en = ($urandom_range(0, 1) == 1);
      else if (!a1_en) a1_en = ($urandom_range(0, 9) < 4);
      if (a1_en && (a1_ack || !p_e1)) begin
        a1_wr = 1'($urandom_range(0, 1)); a1_addr = $urandom; a1_wd = rand_line();
      end
      mem_resp(am_en, ca, la, 4, am_ack);
      am_rd = rand_line();
      #1;
      eg = (own == 0) ? 2'b01 : ((own == 1) ? 2'b10 : 2'b00);
      chk_a("rand", eg,
            (own == 0) ? a0_wr : ((own == 1) ? a1_wr : 1'b0),
            (own == 0) ? a0_addr : ((own == 1) ? a1_addr : '0),
            (own == 0) ? a0_wd : ((own == 1) ? a1_wd : '0),
            (own == 0) && am_ack, (own == 1) && am_ack, merr);
      p_e0 = a0_en; p_e1 = a1_en; p_ack = am_ack;
      step();
      // model advance over the edge
      if (own >= 0) begin
        if (!(own == 0 ? p_e0 : p_e1)) merr = 1;
        if (p_ack) begin last = own; own = -1; end
      end else begin
        if (p_ack) merr = 1;
        own = pick(p_e0, p_e1, last, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
